alu_flag_stage: RTL and testbench



---
 rtl/alu_flag_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_flag_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_stage.sv
// -----------------------------------------------------------------------------
// alu_flag_stage
//
// Sits directly behind the 64-bit ALU datapath. Every accepted ALU beat:
//   * is forwarded in order through a 2-entry buffer to writeback,
//   * may update the architectural NZCV flags register (Z computed here),
//   * sets a sticky error bit if its op code is illegal,
//   * bumps a saturating counter if it is an add/sub that overflowed.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   in_result         ALU result (WIDTH bits)
//   in_control        ALU op code (000 passB, 010 add, 011 sub, 100 and,
//                     101 or, 110 xor; 001/111 illegal)
//   in_carryout       carry of the selected adder
//   in_overflow       signed overflow of the top bit
//   in_negative       result MSB
//   in_setflags       this beat updates the flags register
//   out_valid/out_ready downstream handshake
//   out_result        head entry result
//   out_control       head entry op code
//   flags             {N,Z,V,C}
//   err_sticky        illegal op seen since last clr_err
//   clr_err           clear err_sticky (a same-cycle illegal beat wins)
//   ovf_count         saturating count of overflowing add/sub beats
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. in_ready is a pure function of the registered occupancy (count < 2),
// so it never depends combinationally on out_ready; a full buffer refuses a
// push even when the head is popped in the same cycle. out_valid is also
// registered, and out_result/out_control hold while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module alu_flag_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_control,
  input  logic             in_carryout,
  input  logic             in_overflow,
  input  logic             in_negative,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_control,
  output logic [3:0]       flags,
  output logic             err_sticky,
  input  logic             clr_err,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ILL0  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_ILL1  = 3'b111;

  // Buffer state: head entry drives the outputs, tail holds the second beat.
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_result_q, head_result_d;
  logic [2:0]       head_control_q, head_control_d;
  logic [WIDTH-1:0] tail_result_q, tail_result_d;
  logic [2:0]       tail_control_q, tail_control_d;

  // Architectural / statistics state.
  logic [3:0]       flags_q, flags_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  // Beat classification.
  logic push, pop;
  logic op_arith, op_illegal, result_zero;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign op_arith    = (in_control == OP_ADD) || (in_control == OP_SUB);
  assign op_illegal  = (in_control == OP_ILL0) || (in_control == OP_ILL1);
  assign result_zero = (in_result == '0);

  // ---------------------------------------------------------------------------
  // Buffer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d        = count_q;
    head_result_d  = head_result_q;
    head_control_d = head_control_q;
    tail_result_d  = tail_result_q;
    tail_control_d = tail_control_q;

    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_result_d  = in_result;
          head_control_d = in_control;
          count_d        = 2'd1;
        end else begin
          tail_result_d  = in_result;
          tail_control_d = in_control;
          count_d        = 2'd2;
        end
      end
      2'b01: begin
        // Advance the tail into the head; when draining the last entry the
        // head keeps its stale contents, out_valid masks them.
        if (count_q == 2'd2) begin
          head_result_d  = tail_result_q;
          head_control_d = tail_control_q;
          count_d        = 2'd1;
        end else begin
          count_d        = 2'd0;
        end
      end
      2'b11: begin
        // push requires count<2 and pop requires count>0, so count is 1 here:
        // the old head leaves and the new beat takes its place.
        head_result_d  = in_result;
        head_control_d = in_control;
        count_d        = 2'd1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Flags, sticky error and overflow counter
  // ---------------------------------------------------------------------------
  always_comb begin
    flags_d = flags_q;
    if (push && in_setflags && !op_illegal) begin
      // {N,Z,V,C}; logical ops and passB clear V and C.
      flags_d[3] = in_negative;
      flags_d[2] = result_zero;
      flags_d[1] = op_arith ? in_overflow : 1'b0;
      flags_d[0] = op_arith ? in_carryout : 1'b0;
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_sticky_d = 1'b0;
    end
    // Set after clear so a simultaneous illegal beat keeps the bit high.
    if (push && op_illegal) begin
      err_sticky_d = 1'b1;
    end
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (push && op_arith && in_overflow && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= 2'd0;
      head_result_q  <= '0;
      head_control_q <= OP_PASSB;
      tail_result_q  <= '0;
      tail_control_q <= OP_PASSB;
      flags_q        <= 4'b0000;
      err_sticky_q   <= 1'b0;
      ovf_count_q    <= '0;
    end else begin
      count_q        <= count_d;
      head_result_q  <= head_result_d;
      head_control_q <= head_control_d;
      tail_result_q  <= tail_result_d;
      tail_control_q <= tail_control_d;
      flags_q        <= flags_d;
      err_sticky_q   <= err_sticky_d;
      ovf_count_q    <= ovf_count_d;
    end
  end

  assign out_result  = head_result_q;
  assign out_control = head_control_q;
  assign flags       = flags_q;
  assign err_sticky  = err_sticky_q;
  assign ovf_count   = ovf_count_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_flag_stage
//
// Directed stimulus against alu_flag_stage. A behavioural model (queue of
// expected beats plus flag/error/counter variables) is stepped on each rising
// edge from the driven inputs, and every cycle the DUT outputs are compared
// against it half a cycle later. Hand-computed literal expectations pin the
// model at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_alu_flag_stage;

  localparam int WIDTH = 64;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_control;
  logic             in_carryout;
  logic             in_overflow;
  logic             in_negative;
  logic             in_setflags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_control;
  logic [3:0]       flags;
  logic             err_sticky;
  logic             clr_err;
  logic [CNT_W-1:0] ovf_count;

  always #5 clk = ~clk;

  alu_flag_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_control  (in_control),
    .in_carryout (in_carryout),
    .in_overflow (in_overflow),
    .in_negative (in_negative),
    .in_setflags (in_setflags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_control (out_control),
    .flags       (flags),
    .err_sticky  (err_sticky),
    .clr_err     (clr_err),
    .ovf_count   (ovf_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q[$];
  logic [2:0]       exp_ctrl_q[$];
  logic [3:0]       m_flags;
  logic             m_err;
  int               m_ovf;
  int               n_checks = 0;
  int               n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ctrl_q.delete();
    m_flags = 4'b0000;
    m_err   = 1'b0;
    m_ovf   = 0;
  endtask

  // Architectural behaviour of one rising edge, from the driven inputs.
  task automatic model_step();
    bit accept, take, arith, illegal;
    accept  = in_valid && (exp_q.size() < 2);
    take    = (exp_q.size() > 0) && out_ready;
    arith   = (in_control == 3'b010) || (in_control == 3'b011);
    illegal = (in_control == 3'b001) || (in_control == 3'b111);
    if (take) begin
      void'(exp_q.pop_front());
      void'(exp_ctrl_q.pop_front());
    end
    if (accept) begin
      exp_q.push_back(in_result);
      exp_ctrl_q.push_back(in_control);
      if (in_setflags && !illegal)
        m_flags = {in_negative, (in_result == 0), arith && in_overflow, arith && in_carryout};
      if (arith && in_overflow && m_ovf < (2**CNT_W - 1))
        m_ovf = m_ovf + 1;
    end
    if (accept && illegal) m_err = 1'b1;
    else if (clr_err)      m_err = 1'b0;
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      chk("out_result", out_result, exp_q[0]);
      chk("out_control", 64'(out_control), 64'(exp_ctrl_q[0]));
    end
    chk("flags", 64'(flags), 64'(m_flags));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
  endtask

  // One clock: model sees the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [2:0] ctrl, input logic [WIDTH-1:0] res,
                       input logic c, input logic v, input logic n, input logic sf);
    in_valid    = 1'b1;
    in_control  = ctrl;
    in_result   = res;
    in_carryout = c;
    in_overflow = v;
    in_negative = n;
    in_setflags = sf;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_setflags = 1'b0;
  endtask

  logic [WIDTH-1:0] beat_a, beat_b, beat_c;

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    drive(3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_result", out_result, 64'd0);
    chk("rst out_control", 64'(out_control), 64'd0);
    chk("rst flags", 64'(flags), 64'd0);
    chk("rst err", 64'(err_sticky), 64'd0);
    chk("rst ovf", 64'(ovf_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic flow: add with zero result and carry.
    drive(3'b010, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("basic out_valid", 64'(out_valid), 64'd1);
    chk("basic out_result", out_result, 64'd0);
    chk("basic out_control", 64'(out_control), 64'b010);
    chk("basic flags", 64'(flags), 64'b0101);
    tick();

    // Sub overflow, then xor clears flags.
    drive(3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("sub flags", 64'(flags), 64'b0011);
    chk("sub ovf", 64'(ovf_count), 64'd1);
    drive(3'b110, 64'h0000_0000_0000_1234, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("xor flags", 64'(flags), 64'b0000);
    tick();

    // Backpressure: three beats against a stalled sink.
    beat_a = 64'hAAAA_0000_0000_0001;
    beat_b = 64'hBBBB_0000_0000_0002;
    beat_c = 64'hCCCC_0000_0000_0003;
    out_ready = 1'b0;
    drive(3'b100, beat_a, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(3'b101, beat_b, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(3'b110, beat_c, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp in_ready full", 64'(in_ready), 64'd0);
    chk("bp head A", out_result, beat_a);
    repeat (3) tick();
    chk("bp head A stable", out_result, beat_a);
    chk("bp ctrl A stable", 64'(out_control), 64'b100);
    out_ready = 1'b1;
    tick();
    chk("bp head B", out_result, beat_b);
    tick();
    idle();
    chk("bp head C", out_result, beat_c);
    chk("bp count one", 64'(in_ready), 64'd1);
    tick();
    chk("bp drained", 64'(out_valid), 64'd0);

    // Illegal op: give flags a known non-zero value first.
    drive(3'b000, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("passB flags", 64'(flags), 64'b0100);
    drive(3'b111, 64'hFFFF_0000_0000_0005, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("ill err", 64'(err_sticky), 64'd1);
    chk("ill flags hold", 64'(flags), 64'b0100);
    chk("ill forwarded", 64'(out_control), 64'b111);
    drive(3'b001, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_err = 1'b1;
    tick();
    idle();
    chk("ill set wins", 64'(err_sticky), 64'd1);
    tick();
    clr_err = 1'b0;
    chk("ill cleared", 64'(err_sticky), 64'd0);
    tick();

    // Saturation: 300 overflowing adds, then a clean one.
    for (int i = 0; i < 300; i++) begin
      drive(3'b010, 64'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("sat ovf", 64'(ovf_count), 64'(CNT_MAX));
    drive(3'b010, 64'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("sat hold", 64'(ovf_count), 64'(CNT_MAX));
    tick();

    // Async reset with two entries buffered.
    out_ready = 1'b0;
    drive(3'b010, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(3'b011, 64'h0000_0000_0000_0042, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("pre-rst full", 64'(in_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst flags", 64'(flags), 64'd0);
    chk("arst ovf", 64'(ovf_count), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    model_reset();
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    drive(3'b101, 64'h0000_0000_0000_00F0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("post-rst result", out_result, 64'h0000_0000_0000_00F0);
    chk("post-rst flags", 64'(flags), 64'b0000);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
